pool_flatten: RTL and testbench

Layer-1/layer-2 post-processing stage directly downstream of the layer-0 convolution engine. Once both 64×64 ReLU'd feature maps sit in the L0 memories, it runs 2×2/stride-2 max-pooling on each map and writes the 32×32 results to the L1 memories. Optionally, it also writes the channel-interleaved flattened vector to the L2 memory. It shares the `cwr/caddr_wr/cdata_wr/crd/caddr_rd/cdata_rd/csel` memory bus with the convolution engine and is started when that engine drops busy.

---
 rtl/pool_flatten_pkg.sv | 34 +++
 rtl/pool_flatten_max_track.sv | 31 +++
 rtl/pool_flatten.sv | 152 +++++++++++++++
 tb/tb_pool_flatten.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pool_flatten_pkg.sv
// Shared constants for pool_flatten: memory-select codes, FSM encodings and
// map-geometry constants derived from the L0 map width.
package pool_flatten_pkg;

  localparam int unsigned L0_W     = 64;
  localparam int unsigned POOL_W   = L0_W / 2;
  localparam int unsigned POOL_XW  = $clog2(POOL_W);
  localparam int unsigned POOL_PW  = 2 * POOL_XW;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WR_L1 = 3'd2;
  localparam logic [2:0] ST_WR_L2 = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Offset of the k-th pixel of a 2x2 window from its top-left address.
  function automatic logic [11:0] win_offset(input logic [1:0] k, input int unsigned w);
    case (k)
      2'd0:    win_offset = 12'd0;
      2'd1:    win_offset = 12'd1;
      2'd2:    win_offset = 12'(w);
      default: win_offset = 12'(w + 1);
    endcase
  endfunction

endpackage

// File: rtl/pool_flatten_max_track.sv
// Running-maximum register for one pooling window; unsigned compare, ties keep
// the earlier value. max_nxt_o is the value the register takes at the next edge.
module max_track #(
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          upd_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] max_nxt_o
);

  logic [DW-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (load_i)
      max_d = data_i;
    else if (upd_i && (data_i > max_q))
      max_d = data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) max_q <= '0;
    else     max_q <= max_d;
  end

  assign max_nxt_o = max_d;

endmodule

// File: rtl/pool_flatten.sv
// 2x2/stride-2 max-pool of both L0 maps into L1; optional channel-interleaved
// flatten into L2 when FLATTEN_EN is defined. All outputs are registered.
module pool_flatten
  import pool_flatten_pkg::*;
#(
  parameter int unsigned DW    = 20,
  parameter int unsigned IMG_W = L0_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          crd,
  output logic [11:0]   caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [11:0]   caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int unsigned XW = $clog2(IMG_W / 2);
  localparam int unsigned PW = 2 * XW;

  logic [2:0]    state_q, state_d;
  logic          kernel_q, kernel_d;
  logic [PW-1:0] p_q, p_d;
  logic [2:0]    k_q, k_d;

  logic          done_q, done_d, crd_q, crd_d, cwr_q, cwr_d;
  logic [11:0]   caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
  logic [DW-1:0] cdata_wr_q, cdata_wr_d;
  logic [2:0]    csel_q, csel_d;

  logic          max_load, max_upd;
  logic [DW-1:0] max_nxt;

  max_track #(.DW(DW)) u_max (
    .clk      (clk),
    .rst      (reset),
    .load_i   (max_load),
    .upd_i    (max_upd),
    .data_i   (cdata_rd),
    .max_nxt_o(max_nxt)
  );

  assign max_load = (state_q == ST_READ) && (k_q == 3'd1);
  assign max_upd  = (state_q == ST_READ) && (k_q >= 3'd2);

  always_comb begin
    state_d  = state_q;
    kernel_d = kernel_q;
    p_d      = p_q;
    k_d      = k_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_READ;
          kernel_d = 1'b0;
          p_d      = '0;
          k_d      = '0;
        end
      end
      ST_READ: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd4) state_d = ST_WR_L1;
      end
      ST_WR_L1: begin
`ifdef FLATTEN_EN
        state_d = ST_WR_L2;
`else
        state_d = ST_NEXT;
`endif
      end
      ST_WR_L2: state_d = ST_NEXT;
      ST_NEXT: begin
        k_d = '0;
        if (p_q == '1 && kernel_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
          p_d     = p_q + 1'b1;
          if (p_q == '1) kernel_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up
  // with the cycle the FSM is actually in.
  always_comb begin
    done_d     = (state_d == ST_DONE);
    crd_d      = (state_d == ST_READ) && (k_d != 3'd4);
    cwr_d      = (state_d == ST_WR_L1) || (state_d == ST_WR_L2);
    caddr_rd_d = caddr_rd_q;
    caddr_wr_d = caddr_wr_q;
    cdata_wr_d = cdata_wr_q;
    csel_d     = csel_q;
    if (crd_d) begin
      csel_d     = kernel_d ? CSEL_L0K1 : CSEL_L0K0;
      caddr_rd_d = 12'({p_d[PW-1:XW], 1'b0, p_d[XW-1:0], 1'b0}) + win_offset(k_d[1:0], IMG_W);
    end
    if (state_d == ST_WR_L1) begin
      csel_d     = kernel_d ? CSEL_L1K1 : CSEL_L1K0;
      caddr_wr_d = 12'(p_d);
      cdata_wr_d = max_nxt;
    end
    if (state_d == ST_WR_L2) begin
      csel_d     = CSEL_L2;
      caddr_wr_d = 12'({p_d, kernel_d});
      cdata_wr_d = max_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      kernel_q   <= 1'b0;
      p_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      csel_q     <= CSEL_NONE;
    end else begin
      state_q    <= state_d;
      kernel_q   <= kernel_d;
      p_q        <= p_d;
      k_q        <= k_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      csel_q     <= csel_d;
    end
  end

  assign done     = done_q;
  assign crd      = crd_q;
  assign cwr      = cwr_q;
  assign caddr_rd = caddr_rd_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign csel     = csel_q;

endmodule

// File: tb/tb_pool_flatten.sv
// Directed bench for pool_flatten: memory models for L0/L1/L2, golden pooling
// computed from the L0 contents, cycle-exact timing checks. Honors FLATTEN_EN.
module tb_pool_flatten;
  import pool_flatten_pkg::*;

  localparam int unsigned DW    = 20;
  localparam int unsigned NWIN  = POOL_W * POOL_W;
`ifdef FLATTEN_EN
  localparam int unsigned EXP_DONE = 16385;
  localparam int unsigned EXP_L2   = 2048;
`else
  localparam int unsigned EXP_DONE = 14337;
  localparam int unsigned EXP_L2   = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic          done, crd, cwr;
  logic [11:0]   caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] l0k0 [4096];
  logic [DW-1:0] l0k1 [4096];
  logic [DW-1:0] l1k0 [1024];
  logic [DW-1:0] l1k1 [1024];
  logic [DW-1:0] gold0 [1024];
  logic [DW-1:0] gold1 [1024];
`ifdef FLATTEN_EN
  logic [DW-1:0] l2 [2048];
`endif

  int unsigned n_l1 = 0, n_l2 = 0, n_ovl = 0, n_badsel = 0;
  int unsigned n_tests = 0, n_fail = 0;

  pool_flatten #(.DW(DW), .IMG_W(L0_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .done    (done),
    .crd     (crd),
    .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd),
    .cwr     (cwr),
    .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr),
    .csel    (csel)
  );

  always #5 clk = ~clk;

  // Synchronous memories: read data appears the cycle after crd.
  always @(posedge clk) begin
    if (crd) begin
      case (csel)
        3'b001:  cdata_rd <= l0k0[caddr_rd];
        3'b010:  cdata_rd <= l0k1[caddr_rd];
        default: cdata_rd <= '1;
      endcase
    end
    if (crd && cwr) n_ovl <= n_ovl + 1;
    if (cwr) begin
      case (csel)
        3'b011: begin l1k0[caddr_wr[9:0]] <= cdata_wr; n_l1 <= n_l1 + 1; end
        3'b100: begin l1k1[caddr_wr[9:0]] <= cdata_wr; n_l1 <= n_l1 + 1; end
        3'b101: begin
`ifdef FLATTEN_EN
          l2[caddr_wr[10:0]] <= cdata_wr;
`endif
          n_l2 <= n_l2 + 1;
        end
        default: n_badsel <= n_badsel + 1;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic fill_l0();
    int unsigned base;
    for (int i = 0; i < 4096; i++) begin
      l0k0[i] = DW'($urandom);
      l0k1[i] = DW'($urandom);
    end
    l0k0[0]    = 20'd5;
    l0k0[1]    = 20'd9;
    l0k0[64]   = 20'd9;
    l0k0[65]   = 20'd2;
    l0k1[4030] = 20'h00010;
    l0k1[4031] = 20'h80000;
    l0k1[4094] = 20'h7FFFF;
    l0k1[4095] = 20'h00001;
    for (int unsigned p = 0; p < NWIN; p++) begin
      base = (p / POOL_W) * 2 * L0_W + (p % POOL_W) * 2;
      gold0[p] = max4(l0k0[base], l0k0[base+1], l0k0[base+L0_W], l0k0[base+L0_W+1]);
      gold1[p] = max4(l0k1[base], l0k1[base+1], l0k1[base+L0_W], l0k1[base+L0_W+1]);
    end
  endtask

  task automatic run_job(input string tag, input bit pulse_busy);
    int unsigned i, b_l1, b_l2, b_ovl, b_sel, bad;
    bit seen_wr;
    b_l1 = n_l1; b_l2 = n_l2; b_ovl = n_ovl; b_sel = n_badsel;
    i = 0; seen_wr = 1'b0;
    @(negedge clk);
    start = 1'b1;
    do begin
      @(negedge clk);
      i++;
      start = pulse_busy && (i == 8);
      if (!seen_wr && cwr) begin
        seen_wr = 1'b1;
        check_eq({tag, "_first_wr_cycle"}, i, 6);
        check_eq({tag, "_first_wr_csel"}, csel, 3'b011);
        check_eq({tag, "_first_wr_addr"}, caddr_wr, 0);
        check_eq({tag, "_first_wr_data"}, cdata_wr, 9);
      end
    end while (!done && i < 20000);
    start = 1'b0;
    check_eq({tag, "_first_wr_seen"}, seen_wr, 1);
    check_eq({tag, "_done_cycle"}, i, EXP_DONE);
    check_eq({tag, "_l1_writes"}, n_l1 - b_l1, 2048);
    check_eq({tag, "_l2_writes"}, n_l2 - b_l2, EXP_L2);
    check_eq({tag, "_rd_wr_overlap"}, n_ovl - b_ovl, 0);
    check_eq({tag, "_bad_csel"}, n_badsel - b_sel, 0);
    bad = 0;
    for (int unsigned p = 0; p < NWIN; p++) begin
      if (l1k0[p] !== gold0[p]) bad++;
      if (l1k1[p] !== gold1[p]) bad++;
    end
    check_eq({tag, "_l1_bad_words"}, bad, 0);
    check_eq({tag, "_l1k0_0"}, l1k0[0], 20'd9);
    check_eq({tag, "_l1k1_1023"}, l1k1[1023], 20'h80000);
`ifdef FLATTEN_EN
    bad = 0;
    for (int unsigned p = 0; p < NWIN; p++) begin
      if (l2[2*p] !== l1k0[p]) bad++;
      if (l2[2*p+1] !== l1k1[p]) bad++;
    end
    check_eq({tag, "_l2_bad_words"}, bad, 0);
`endif
  endtask

  initial begin
    int unsigned i, b_l1;
    bit found;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_done", done, 0);
    check_eq("rst_crd", crd, 0);
    check_eq("rst_cwr", cwr, 0);
    check_eq("rst_csel", csel, 0);
    check_eq("rst_caddr_rd", caddr_rd, 0);
    check_eq("rst_caddr_wr", caddr_wr, 0);
    check_eq("rst_cdata_wr", cdata_wr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_done", done, 0);

    fill_l0();
    run_job("run1", 1'b1);
    check_eq("done_held", done, 1);

    fill_l0();
    run_job("rerun", 1'b0);

    // Abort while window p=300 of kernel 0 is being written.
    fill_l0();
    b_l1 = n_l1; i = 0; found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    do begin
      @(negedge clk);
      i++;
      start = 1'b0;
      found = cwr && (csel == 3'b011) && (caddr_wr == 12'd300);
    end while (!found && i < 5000);
    check_eq("abort_point_found", found, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_crd", crd, 0);
    check_eq("abort_cwr", cwr, 0);
    check_eq("abort_csel", csel, 0);
    check_eq("abort_caddr_rd", caddr_rd, 0);
    check_eq("abort_caddr_wr", caddr_wr, 0);
    check_eq("abort_cdata_wr", cdata_wr, 0);
    check_eq("abort_done", done, 0);
    repeat (3) @(negedge clk);
    check_eq("abort_l1_writes", n_l1 - b_l1, 300);
    reset = 1'b0;
    @(negedge clk);
    fill_l0();
    run_job("restart", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
